// File: rtl/lv_pkg.sv
// Shared definitions for the low-voltage die register access path:
// FSM state encodings, response error codes and the CRC-8 polynomial.
package lv_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CHK  = 2'd1;
    localparam state_t ST_ACC  = 2'd2;
    localparam state_t ST_RSP  = 2'd3;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_CRC  = 2'd1;
    localparam logic [1:0] ERR_ADDR = 2'd2;

    localparam logic [7:0] CRC8_POLY = 8'h07;

endpackage

// File: rtl/lv_crc8_calc.sv
// Combinational CRC-8 (MSB first) over a DATA_W-bit word with a configurable seed.
// Shared by the frame layers, the crc watchdog and the register access master.
module lv_crc8_calc
    import lv_pkg::*;
#(
    parameter int         DATA_W = 16,
    parameter logic [7:0] SEED   = 8'hFF
)(
    input  logic [DATA_W-1:0] data,
    output logic [7:0]        crc
);

    logic [7:0] acc;
    logic       fb;

    always_comb begin
        acc = SEED;
        fb  = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb  = acc[7] ^ data[i];
            acc = {acc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
        end
        crc = acc;
    end

endmodule

// File: rtl/lv_reg_acc_mst.sv
// Register-bus initiator: validates command CRC and address, issues one
// registered write/read strobe and returns the result over valid/ready.
module lv_reg_acc_mst
    import lv_pkg::*;
#(
    parameter int              AW       = 7,
    parameter int              DW       = 8,
    parameter int              CRC_W    = 8,
    parameter logic [AW-1:0]   MAX_ADDR = 7'h3F,
    parameter logic [7:0]      CRC_INIT = 8'hFF
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_vld,
    output logic             o_cmd_rdy,
    input  logic             i_cmd_rw,
    input  logic [AW-1:0]    i_cmd_addr,
    input  logic [DW-1:0]    i_cmd_wdata,
    input  logic [CRC_W-1:0] i_cmd_crc,
    input  logic             i_abort,
    output logic             o_wen,
    output logic             o_ren,
    output logic [AW-1:0]    o_addr,
    output logic [DW-1:0]    o_wdata,
    output logic [CRC_W-1:0] o_crc_data,
    input  logic [DW-1:0]    i_rdata,
    input  logic [CRC_W-1:0] i_rcrc,
    output logic             o_rsp_vld,
    input  logic             i_rsp_rdy,
    output logic [DW-1:0]    o_rsp_rdata,
    output logic [CRC_W-1:0] o_rsp_rcrc,
    output logic [1:0]       o_rsp_err,
    output logic             o_crc_err
);

    state_t             state;
    state_t             state_nxt;
    logic               lat_rw;
    logic [AW-1:0]      lat_addr;
    logic [DW-1:0]      lat_wdata;
    logic [CRC_W-1:0]   lat_crc;
    logic [AW+DW:0]     crc_in;
    logic [7:0]         calc_crc;
    logic               crc_bad;
    logic               addr_bad;
    logic               cmd_take;

    // Reads carry no data, so the data field is zeroed before the CRC.
    assign crc_in   = {lat_rw, lat_addr, (lat_rw ? lat_wdata : {DW{1'b0}})};
    assign crc_bad  = (calc_crc != lat_crc);
    assign addr_bad = (lat_addr > MAX_ADDR);

    lv_crc8_calc #(
        .DATA_W (AW + DW + 1),
        .SEED   (CRC_INIT)
    ) u_crc (
        .data (crc_in),
        .crc  (calc_crc)
    );

    assign o_cmd_rdy = (state == ST_IDLE) && !i_abort;
    assign o_rsp_vld = (state == ST_RSP);
    assign cmd_take  = i_cmd_vld && o_cmd_rdy;

    always_comb begin
        state_nxt = state;
        if (i_abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (cmd_take) state_nxt = ST_CHK;
                ST_CHK:  state_nxt = (crc_bad || addr_bad) ? ST_RSP : ST_ACC;
                ST_ACC:  state_nxt = ST_RSP;
                ST_RSP:  if (i_rsp_rdy) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lat_rw    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_crc   <= '0;
        end else if (cmd_take) begin
            lat_rw    <= i_cmd_rw;
            lat_addr  <= i_cmd_addr;
            lat_wdata <= i_cmd_wdata;
            lat_crc   <= i_cmd_crc;
        end
    end

    // Bus outputs default to zero every cycle so only the ACC cycle is non-quiet.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wen      <= 1'b0;
            o_ren      <= 1'b0;
            o_addr     <= '0;
            o_wdata    <= '0;
            o_crc_data <= '0;
            o_crc_err  <= 1'b0;
        end else begin
            o_wen      <= 1'b0;
            o_ren      <= 1'b0;
            o_addr     <= '0;
            o_wdata    <= '0;
            o_crc_data <= '0;
            o_crc_err  <= (state == ST_CHK) && crc_bad && !i_abort;
            if ((state == ST_CHK) && !i_abort && !crc_bad && !addr_bad) begin
                o_wen      <= lat_rw;
                o_ren      <= !lat_rw;
                o_addr     <= lat_addr;
                o_wdata    <= lat_wdata;
                o_crc_data <= lat_crc;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp_rdata <= '0;
            o_rsp_rcrc  <= '0;
            o_rsp_err   <= ERR_OK;
        end else begin
            case (state)
                ST_CHK: if (!i_abort && (crc_bad || addr_bad)) begin
                    o_rsp_rdata <= '0;
                    o_rsp_rcrc  <= '0;
                    o_rsp_err   <= crc_bad ? ERR_CRC : ERR_ADDR;
                end
                // Slaves answer combinationally on ren, so capture in the strobe cycle.
                ST_ACC: if (!i_abort) begin
                    o_rsp_rdata <= lat_rw ? {DW{1'b0}} : i_rdata;
                    o_rsp_rcrc  <= lat_rw ? {CRC_W{1'b0}} : i_rcrc;
                    o_rsp_err   <= ERR_OK;
                end
                ST_RSP: if (i_rsp_rdy || i_abort) begin
                    o_rsp_rdata <= '0;
                    o_rsp_rcrc  <= '0;
                    o_rsp_err   <= ERR_OK;
                end
                default: ;
            endcase
        end
    end

    wen_ren_exclusive: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(o_wen && o_ren));

endmodule

// File: tb/tb_lv_reg_acc_mst.sv
// Directed self-checking bench for lv_reg_acc_mst: write/read paths, CRC and
// address errors, response backpressure, abort handling and async reset.
module tb_lv_reg_acc_mst;

    logic       clk;
    logic       rst_n;
    logic       cmd_vld;
    logic       cmd_rdy;
    logic       cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [7:0] cmd_crc;
    logic       abort;
    logic       wen;
    logic       ren;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] crc_data;
    logic [7:0] rdata;
    logic [7:0] rcrc;
    logic       rsp_vld;
    logic       rsp_rdy;
    logic [7:0] rsp_rdata;
    logic [7:0] rsp_rcrc;
    logic [1:0] rsp_err;
    logic       crc_err;

    logic [7:0] slave_data;
    logic [7:0] slave_crc;

    int n_checks = 0;
    int n_fail   = 0;

    lv_reg_acc_mst dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd_vld   (cmd_vld),
        .o_cmd_rdy   (cmd_rdy),
        .i_cmd_rw    (cmd_rw),
        .i_cmd_addr  (cmd_addr),
        .i_cmd_wdata (cmd_wdata),
        .i_cmd_crc   (cmd_crc),
        .i_abort     (abort),
        .o_wen       (wen),
        .o_ren       (ren),
        .o_addr      (addr),
        .o_wdata     (wdata),
        .o_crc_data  (crc_data),
        .i_rdata     (rdata),
        .i_rcrc      (rcrc),
        .o_rsp_vld   (rsp_vld),
        .i_rsp_rdy   (rsp_rdy),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_rcrc  (rsp_rcrc),
        .o_rsp_err   (rsp_err),
        .o_crc_err   (crc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: read data appears only while the read strobe is high.
    assign rdata = ren ? slave_data : 8'h00;
    assign rcrc  = ren ? slave_crc  : 8'h00;

    // Byte-wise CRC-8, poly 0x07, seed 0xFF, over {rw,addr} then data (0 for reads).
    function automatic logic [7:0] crc_model(input logic rw, input logic [6:0] a, input logic [7:0] d);
        logic [7:0] bytes [2];
        logic [7:0] c;
        bytes[0] = {rw, a};
        bytes[1] = rw ? d : 8'h00;
        c = 8'hFF;
        for (int b = 0; b < 2; b++) begin
            c = c ^ bytes[b];
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a command for one cycle; returns just after the accepting edge.
    task automatic send_cmd(input logic rw, input logic [6:0] a, input logic [7:0] d, input logic [7:0] c);
        cmd_vld   = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_crc   = c;
        step();
        cmd_vld   = 1'b0;
        cmd_rw    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_crc   = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_cmd_rdy: got %0h want 1", cmd_rdy); end
        n_checks++; if ({wen, ren, addr, wdata, crc_data} !== 25'd0) begin n_fail++; $display("[TB] FAIL rst_bus: got %h want 0", {wen, ren, addr, wdata, crc_data}); end
        n_checks++; if ({rsp_vld, rsp_rdata, rsp_rcrc, rsp_err, crc_err} !== 20'd0) begin n_fail++; $display("[TB] FAIL rst_rsp: got %h want 0", {rsp_vld, rsp_rdata, rsp_rcrc, rsp_err, crc_err}); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write();
        logic [7:0] c;
        c = crc_model(1'b1, 7'h05, 8'hA5);
        send_cmd(1'b1, 7'h05, 8'hA5, c);
        n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_busy: got %0h want 0", cmd_rdy); end
        n_checks++; if (wen !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_early_wen: got %0h want 0", wen); end
        step();
        n_checks++; if ({wen, ren} !== 2'b10) begin n_fail++; $display("[TB] FAIL wr_strobe: got %b want 10", {wen, ren}); end
        n_checks++; if ({addr, wdata, crc_data} !== {7'h05, 8'hA5, c}) begin n_fail++; $display("[TB] FAIL wr_bus: got %h want %h", {addr, wdata, crc_data}, {7'h05, 8'hA5, c}); end
        n_checks++; if (rsp_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_early_rsp: got %0h want 0", rsp_vld); end
        step();
        n_checks++; if ({wen, addr, wdata, crc_data} !== 24'd0) begin n_fail++; $display("[TB] FAIL wr_bus_quiet: got %h want 0", {wen, addr, wdata, crc_data}); end
        n_checks++; if ({rsp_vld, rsp_err, rsp_rdata, crc_err} !== {1'b1, 2'd0, 8'h00, 1'b0}) begin n_fail++; $display("[TB] FAIL wr_rsp: got %h want %h", {rsp_vld, rsp_err, rsp_rdata, crc_err}, {1'b1, 2'd0, 8'h00, 1'b0}); end
        step();
        n_checks++; if ({rsp_vld, cmd_rdy} !== 2'b01) begin n_fail++; $display("[TB] FAIL wr_idle: got %b want 01", {rsp_vld, cmd_rdy}); end
    endtask

    task automatic test_read();
        logic [7:0] c;
        slave_data = 8'hA5;
        slave_crc  = 8'h3C;
        c = crc_model(1'b0, 7'h05, 8'h00);
        send_cmd(1'b0, 7'h05, 8'h77, c);
        n_checks++; if (ren !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_early_ren: got %0h want 0", ren); end
        step();
        n_checks++; if ({wen, ren, addr} !== {2'b01, 7'h05}) begin n_fail++; $display("[TB] FAIL rd_strobe: got %h want %h", {wen, ren, addr}, {2'b01, 7'h05}); end
        step();
        n_checks++; if ({rsp_vld, ren} !== 2'b10) begin n_fail++; $display("[TB] FAIL rd_rsp_timing: got %b want 10", {rsp_vld, ren}); end
        n_checks++; if ({rsp_rdata, rsp_rcrc, rsp_err} !== {8'hA5, 8'h3C, 2'd0}) begin n_fail++; $display("[TB] FAIL rd_rsp_data: got %h want %h", {rsp_rdata, rsp_rcrc, rsp_err}, {8'hA5, 8'h3C, 2'd0}); end
        step();
        n_checks++; if ({rsp_vld, rsp_rdata, rsp_rcrc} !== 17'd0) begin n_fail++; $display("[TB] FAIL rd_rsp_clear: got %h want 0", {rsp_vld, rsp_rdata, rsp_rcrc}); end
    endtask

    task automatic test_crc_error();
        logic [7:0] c;
        c = crc_model(1'b1, 7'h05, 8'hA5) ^ 8'h01;
        send_cmd(1'b1, 7'h05, 8'hA5, c);
        n_checks++; if (crc_err !== 1'b0) begin n_fail++; $display("[TB] FAIL crc_pulse_early: got %0h want 0", crc_err); end
        step();
        n_checks++; if ({crc_err, wen, rsp_vld, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b1, 2'd1, 8'h00}) begin n_fail++; $display("[TB] FAIL crc_rsp: got %h want %h", {crc_err, wen, rsp_vld, rsp_err, rsp_rdata}, {1'b1, 1'b0, 1'b1, 2'd1, 8'h00}); end
        step();
        n_checks++; if ({crc_err, wen, rsp_vld} !== 3'b000) begin n_fail++; $display("[TB] FAIL crc_pulse_once: got %b want 000", {crc_err, wen, rsp_vld}); end
        c = crc_model(1'b1, 7'h7F, 8'hA5) ^ 8'h01;
        send_cmd(1'b1, 7'h7F, 8'hA5, c);
        step();
        n_checks++; if ({crc_err, rsp_vld, rsp_err} !== {1'b1, 1'b1, 2'd1}) begin n_fail++; $display("[TB] FAIL crc_priority: got %h want %h", {crc_err, rsp_vld, rsp_err}, {1'b1, 1'b1, 2'd1}); end
        step();
    endtask

    task automatic test_addr_error();
        logic [7:0] c;
        slave_data = 8'h99;
        slave_crc  = 8'h11;
        c = crc_model(1'b0, 7'h40, 8'h00);
        send_cmd(1'b0, 7'h40, 8'h00, c);
        step();
        n_checks++; if ({ren, crc_err, rsp_vld, rsp_err, rsp_rdata} !== {1'b0, 1'b0, 1'b1, 2'd2, 8'h00}) begin n_fail++; $display("[TB] FAIL addr_err_rsp: got %h want %h", {ren, crc_err, rsp_vld, rsp_err, rsp_rdata}, {1'b0, 1'b0, 1'b1, 2'd2, 8'h00}); end
        step();
        n_checks++; if ({rsp_vld, ren} !== 2'b00) begin n_fail++; $display("[TB] FAIL addr_err_done: got %b want 00", {rsp_vld, ren}); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] c;
        slave_data = 8'h5E;
        slave_crc  = 8'hC3;
        rsp_rdy    = 1'b0;
        c = crc_model(1'b0, 7'h2A, 8'h00);
        send_cmd(1'b0, 7'h2A, 8'h00, c);
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            n_checks++; if ({rsp_vld, cmd_rdy, rsp_rdata, rsp_rcrc, rsp_err} !== {2'b10, 8'h5E, 8'hC3, 2'd0}) begin n_fail++; $display("[TB] FAIL hold_rsp_%0d: got %h want %h", i, {rsp_vld, cmd_rdy, rsp_rdata, rsp_rcrc, rsp_err}, {2'b10, 8'h5E, 8'hC3, 2'd0}); end
            step();
        end
        rsp_rdy = 1'b1;
        step();
        n_checks++; if ({rsp_vld, cmd_rdy, rsp_rdata} !== {2'b01, 8'h00}) begin n_fail++; $display("[TB] FAIL hold_release: got %h want %h", {rsp_vld, cmd_rdy, rsp_rdata}, {2'b01, 8'h00}); end
        c = crc_model(1'b1, 7'h3F, 8'h0F);
        send_cmd(1'b1, 7'h3F, 8'h0F, c);
        n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL second_accept: got %0h want 0", cmd_rdy); end
        step();
        n_checks++; if ({wen, addr, wdata} !== {1'b1, 7'h3F, 8'h0F}) begin n_fail++; $display("[TB] FAIL second_write: got %h want %h", {wen, addr, wdata}, {1'b1, 7'h3F, 8'h0F}); end
        step();
        step();
    endtask

    task automatic test_abort();
        logic [7:0] c;
        c = crc_model(1'b1, 7'h05, 8'hA5);
        send_cmd(1'b1, 7'h05, 8'hA5, c);
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        n_checks++; if ({wen, rsp_vld, cmd_rdy} !== 3'b001) begin n_fail++; $display("[TB] FAIL abort_chk: got %b want 001", {wen, rsp_vld, cmd_rdy}); end
        step();
        n_checks++; if ({wen, rsp_vld} !== 2'b00) begin n_fail++; $display("[TB] FAIL abort_chk_quiet: got %b want 00", {wen, rsp_vld}); end
        send_cmd(1'b1, 7'h05, 8'hA5, c);
        step();
        abort = 1'b1;
        #1;
        n_checks++; if (wen !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_acc_strobe: got %0h want 1", wen); end
        step();
        abort = 1'b0;
        #1;
        n_checks++; if ({wen, rsp_vld, cmd_rdy} !== 3'b001) begin n_fail++; $display("[TB] FAIL abort_acc_norsp: got %b want 001", {wen, rsp_vld, cmd_rdy}); end
        cmd_vld  = 1'b1;
        cmd_rw   = 1'b1;
        cmd_addr = 7'h05;
        cmd_crc  = c;
        abort    = 1'b1;
        #1;
        n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_idle_rdy: got %0h want 0", cmd_rdy); end
        step();
        cmd_vld = 1'b0;
        abort   = 1'b0;
        #1;
        n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_idle_noaccept: got %0h want 1", cmd_rdy); end
        step();
        n_checks++; if ({wen, ren} !== 2'b00) begin n_fail++; $display("[TB] FAIL abort_idle_nostrobe: got %b want 00", {wen, ren}); end
    endtask

    task automatic test_async_reset();
        logic [7:0] c;
        slave_data = 8'h6B;
        slave_crc  = 8'h2D;
        rsp_rdy    = 1'b0;
        c = crc_model(1'b0, 7'h10, 8'h00);
        send_cmd(1'b0, 7'h10, 8'h00, c);
        step();
        step();
        n_checks++; if ({rsp_vld, rsp_rdata} !== {1'b1, 8'h6B}) begin n_fail++; $display("[TB] FAIL arst_pre: got %h want %h", {rsp_vld, rsp_rdata}, {1'b1, 8'h6B}); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({rsp_vld, rsp_rdata, rsp_rcrc, rsp_err, cmd_rdy} !== {1'b0, 8'h00, 8'h00, 2'd0, 1'b1}) begin n_fail++; $display("[TB] FAIL arst_rsp: got %h want %h", {rsp_vld, rsp_rdata, rsp_rcrc, rsp_err, cmd_rdy}, {1'b0, 8'h00, 8'h00, 2'd0, 1'b1}); end
        n_checks++; if ({wen, ren, addr, wdata, crc_data, crc_err} !== 26'd0) begin n_fail++; $display("[TB] FAIL arst_bus: got %h want 0", {wen, ren, addr, wdata, crc_data, crc_err}); end
        @(negedge clk);
        rst_n   = 1'b1;
        rsp_rdy = 1'b1;
        step();
    endtask

    initial begin
        cmd_vld    = 1'b0;
        cmd_rw     = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        cmd_crc    = '0;
        abort      = 1'b0;
        rsp_rdy    = 1'b1;
        slave_data = 8'h00;
        slave_crc  = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_crc_error();
        test_addr_error();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
